// File: rtl/noc_mesh_router_buf.sv
// noc_mesh_router_buf: buffered 5-port XY mesh router with per-input FIFOs,
// round-robin output arbitration, registered outputs and malformed-hop dropping.
`default_nettype none

module noc_mesh_router_buf #(
  parameter int WIDTH     = 53,
  parameter int DEPTH     = 4,
  parameter int HOP_BITS  = 3,
  parameter int X_HOP_LOC = 4,
  parameter int Y_HOP_LOC = 7,
  parameter int X_DIR_LOC = 10,
  parameter int Y_DIR_LOC = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  input  logic [5*WIDTH-1:0] in_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [5*WIDTH-1:0] out_data,
  output logic [7:0]         drop_cnt
);

  localparam int NP = 5;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [HOP_BITS-1:0] HOP_ONE = HOP_BITS'(1);

  logic [WIDTH-1:0] mem [NP][DEPTH];
  logic [PW-1:0]    wr_ptr [NP];
  logic [PW-1:0]    rd_ptr [NP];
  logic [CW-1:0]    count [NP];
  logic [CW-1:0]    count_nxt [NP];
  logic [WIDTH-1:0] head [NP];
  logic [WIDTH-1:0] fwd [NP];
  logic [NP-1:0]    req [NP];
  logic [2:0]       rr [NP];
  logic [2:0]       grant_src [NP];
  logic [NP-1:0]    grant_out;
  logic [NP-1:0]    granted;
  logic [NP-1:0]    bad;
  logic [NP-1:0]    push;
  logic [NP-1:0]    pop;
  logic [2:0]       n_bad;
  logic [8:0]       drop_sum;

  // Thermometer-from-MSB: the complement is a contiguous run of ones from the LSB.
  function automatic logic is_therm(input logic [HOP_BITS-1:0] v);
    logic [HOP_BITS-1:0] nv;
    nv = ~v;
    return (nv & (nv + HOP_ONE)) == '0;
  endfunction

  assign push = in_valid & in_ready;
  assign pop  = granted | bad;

  always_comb begin
    logic [HOP_BITS-1:0] xh;
    logic [HOP_BITS-1:0] yh;
    xh    = '0;
    yh    = '0;
    n_bad = '0;
    for (int p = 0; p < NP; p++) begin
      head[p]      = mem[p][rd_ptr[p]];
      fwd[p]       = head[p];
      req[p]       = '0;
      bad[p]       = 1'b0;
      count_nxt[p] = count[p] + CW'(push[p]) - CW'(pop[p]);
      xh = head[p][X_HOP_LOC +: HOP_BITS];
      yh = head[p][Y_HOP_LOC +: HOP_BITS];
      if (count[p] != '0) begin
        if (!is_therm(xh) || !is_therm(yh)) begin
          bad[p] = 1'b1;
        end else if (xh != '0) begin
          req[p][head[p][X_DIR_LOC] ? 4 : 3] = 1'b1;
          fwd[p][X_HOP_LOC +: HOP_BITS] = xh << 1;
        end else if (yh != '0) begin
          req[p][head[p][Y_DIR_LOC] ? 2 : 1] = 1'b1;
          fwd[p][Y_HOP_LOC +: HOP_BITS] = yh << 1;
        end else begin
          req[p][0] = 1'b1;
        end
      end
      n_bad = n_bad + 3'(bad[p]);
    end
  end

  // Round-robin search per output, starting at rr[o] and wrapping modulo 5.
  always_comb begin
    int idx;
    idx     = 0;
    granted = '0;
    for (int o = 0; o < NP; o++) begin
      grant_out[o] = 1'b0;
      grant_src[o] = '0;
      if (!out_valid[o] || out_ready[o]) begin
        for (int k = 0; k < NP; k++) begin
          idx = int'(rr[o]) + k;
          if (idx >= NP) idx = idx - NP;
          if (!grant_out[o] && req[idx][o]) begin
            grant_out[o] = 1'b1;
            grant_src[o] = 3'(idx);
          end
        end
      end
      if (grant_out[o]) granted[grant_src[o]] = 1'b1;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 9'(n_bad);

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
        rr[p]     <= '0;
      end
      in_ready  <= '1;
      out_valid <= '0;
      out_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PW'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PW'(1);
        count[p]    <= count_nxt[p];
        in_ready[p] <= (count_nxt[p] != CW'(DEPTH));
      end
      for (int o = 0; o < NP; o++) begin
        if (grant_out[o]) begin
          out_data[o*WIDTH +: WIDTH] <= fwd[grant_src[o]];
          out_valid[o] <= 1'b1;
          rr[o]        <= (grant_src[o] == 3'd4) ? 3'd0 : grant_src[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

`default_nettype wire
